psum_drain: RTL

- Read-out side of the partial-sum buffer: once accumulation is finished, streams accumulated rows from the psum BRAM to the downstream post-processing stage.
- Accepts a start command with a base address and row count, and issues BRAM reads.
- Absorbs the fixed BRAM read latency in a small FIFO.
- Presents rows on a valid/ready stream with a last flag. Sits between the psum BRAM read port and the output/requantization path; pe_controller issues the command.

---
 rtl/psum_drain_pkg.sv | 16 +
 rtl/psum_drain_fifo.sv | 54 +++++
 rtl/psum_drain.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/psum_drain_pkg.sv
// Shared definitions for the psum read-out path: default geometry and FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_drain_pkg;

  localparam int PD_ARRAY_DIM  = 16;  // psum lanes per BRAM row
  localparam int PD_ACC_WIDTH  = 32;  // bits per lane
  localparam int PD_ADDR_WIDTH = 10;  // psum BRAM address width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/psum_drain_fifo.sv
// Synchronous FIFO holding returned BRAM rows (data + last tag) for psum_drain.
// Latency: a push is visible at head the cycle after it is written; head is a mux of flops.
// Backpressure: none internally; the writer must never push into a full FIFO without a pop.
// Ports: clk/rst, push/push_data write side, pop/head read side, full/empty/count status.
module psum_drain_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4,                 // power of two, so pointers wrap naturally
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;  // idle, or push+pop with no net change
      endcase
    end
  end

  // Storage is left unreset; readers qualify head with !empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_drain.sv
// Streams a range of accumulated psum rows from BRAM to the post-processing stage.
// Latency: start sampled cycle 0, first bram_ren cycle 1, first m_valid cycle RD_LATENCY+2.
// Backpressure: reads are issued only while fifo_count+inflight < FIFO_DEPTH, so m_ready may stall indefinitely.
// Ports: start/base_addr/num_rows command in, busy/done status out, bram_ren/bram_raddr/bram_rdata
//        BRAM read port, m_valid/m_ready/m_data/m_last output stream.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int ARRAY_DIM  = PD_ARRAY_DIM,
  parameter int ACC_WIDTH  = PD_ACC_WIDTH,
  parameter int ADDR_WIDTH = PD_ADDR_WIDTH,
  parameter int RD_LATENCY = 1,   // 1 or 2
  parameter int FIFO_DEPTH = 4    // power of two, >= RD_LATENCY+2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_ren,
  output logic [ADDR_WIDTH-1:0]          bram_raddr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] bram_rdata,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] m_data,
  output logic                           m_last
);

  localparam int DW = ARRAY_DIM * ACC_WIDTH;
  localparam int NW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  drain_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [NW-1:0]         rows_q;
  logic [NW-1:0]         issued_q;
  logic [CW-1:0]         inflight_q;
  logic [CW-1:0]         fifo_count;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_last_q;
  logic                  done_q;
  logic                  ren;
  logic                  issue_last;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  last_beat;
  logic [DW:0]           fifo_head;

  assign issue_last = (issued_q == rows_q - NW'(1));
  assign fifo_push  = tag_vld_q[RD_LATENCY-1];
  assign fifo_pop   = m_valid && m_ready;
  assign last_beat  = fifo_pop && m_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && num_rows != '0) state_d = ST_READ;
      ST_READ:  if (ren && issue_last)       state_d = ST_FLUSH;
      ST_FLUSH: if (last_beat)               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Outputs: credit check counts both queued rows and reads still in the BRAM pipe,
  // so every issued read has a guaranteed FIFO slot even if m_ready stays low.
  always_comb begin
    ren        = 1'b0;
    bram_raddr = '0;
    busy       = (state_q != ST_IDLE);
    if (state_q == ST_READ && (fifo_count + inflight_q) < DEPTH_C) begin
      ren        = 1'b1;
      bram_raddr = base_q + issued_q[ADDR_WIDTH-1:0];  // wraps modulo 2^ADDR_WIDTH
    end
  end

  assign bram_ren = ren;
  assign done     = done_q;

  // Command latch, issue counter, inflight counter and read-latency tag pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      rows_q     <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FLUSH && last_beat) ||
                (state_q == ST_IDLE && start && num_rows == '0);

      if (state_q == ST_IDLE && start) begin
        base_q   <= base_addr;
        rows_q   <= num_rows;
        issued_q <= '0;
      end else if (ren) begin
        issued_q <= issued_q + NW'(1);
      end

      case ({ren, fifo_push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase

      // The tag pipe mirrors the BRAM latency so returning data is captured exactly once;
      // clearing it on reset drops any read still in flight.
      tag_vld_q[0]  <= ren;
      tag_last_q[0] <= ren && issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  psum_drain_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({tag_last_q[RD_LATENCY-1], bram_rdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are forced low while empty so nothing stale leaks after reset.
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head[DW-1:0] : '0;
  assign m_last  = m_valid && fifo_head[DW];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
